// File: rtl/crossbar_cfg_ctrl.sv
// PMU event crossbar configuration controller: shadow/active routing tables, atomic commit,
// per-output counter gating across the switch. Optional readback: CROSSBAR_CFG_READBACK_EN.
module crossbar_cfg_ctrl #(
  parameter  int N_IN     = 32,
  parameter  int N_OUT    = 24,
  parameter  int XBAR_LAT = 1,
  localparam int SEL_W    = $clog2(N_IN),
  localparam int IDX_W    = $clog2(N_OUT)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic [SEL_W-1:0]       wr_sel_i,
  output logic                   wr_err_o,
  input  logic                   commit_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [N_OUT*SEL_W-1:0] cfg_o,
  output logic [N_OUT-1:0]       gate_o,
  input  logic [IDX_W-1:0]       rd_idx_i,
  output logic [SEL_W-1:0]       rd_shadow_o,
  output logic [SEL_W-1:0]       rd_active_o
);
  localparam int CNT_W = $clog2(XBAR_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_SETTLE} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [N_OUT-1:0]         w_chg;
  logic [N_OUT-1:0]         r_chg_q;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_done;
  logic                     r_wr_err;
  logic                     w_wr_acc;
  logic                     w_wr_ok;
  logic [N_OUT*SEL_W-1:0]   w_shadow_flat;

  assign w_wr_acc = wr_valid_i && wr_ready_o;
  assign w_wr_ok  = (32'(wr_idx_i) < 32'(N_OUT)) && (32'(wr_sel_i) < 32'(N_IN));

  // One shadow/active pair per crossbar output; active only ever loads from shadow in GATE.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_entry
    logic [SEL_W-1:0] r_shadow;
    logic [SEL_W-1:0] r_active;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_shadow <= '0;
        r_active <= '0;
      end else begin
        if (w_wr_acc && w_wr_ok && (32'(wr_idx_i) == gi))
          r_shadow <= wr_sel_i;
        if (r_state == S_GATE)
          r_active <= r_shadow;
      end
    end

    assign w_chg[gi]                        = (r_shadow != r_active);
    assign cfg_o[gi*SEL_W +: SEL_W]         = r_active;
    assign w_shadow_flat[gi*SEL_W +: SEL_W] = r_shadow;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (commit_i) w_state_next = S_GATE;
      S_GATE:   w_state_next = S_SETTLE;
      S_SETTLE: if (r_cnt == '0) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ready_o = (r_state == S_IDLE);
    busy_o     = (r_state != S_IDLE);
    gate_o     = '1;
    case (r_state)
      S_GATE:   gate_o = ~w_chg;
      S_SETTLE: gate_o = ~r_chg_q;
      default:  gate_o = '1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_chg_q  <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_done   <= (r_state == S_SETTLE) && (r_cnt == '0);
      r_wr_err <= w_wr_acc && !w_wr_ok;
      if (r_state == S_GATE) begin
        r_chg_q <= w_chg;
        r_cnt   <= CNT_W'(XBAR_LAT);
      end else if ((r_state == S_SETTLE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign done_o   = r_done;
  assign wr_err_o = r_wr_err;

`ifdef CROSSBAR_CFG_READBACK_EN
  logic [SEL_W-1:0] r_rd_shadow;
  logic [SEL_W-1:0] r_rd_active;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rd_shadow <= '0;
      r_rd_active <= '0;
    end else if (32'(rd_idx_i) < 32'(N_OUT)) begin
      r_rd_shadow <= w_shadow_flat[int'(rd_idx_i)*SEL_W +: SEL_W];
      r_rd_active <= cfg_o[int'(rd_idx_i)*SEL_W +: SEL_W];
    end else begin
      r_rd_shadow <= '0;
      r_rd_active <= '0;
    end
  end

  assign rd_shadow_o = r_rd_shadow;
  assign rd_active_o = r_rd_active;
`else
  // Readback index and shadow copy have no consumer in this build.
  logic w_unused_rd;
  assign w_unused_rd = ^{rd_idx_i, w_shadow_flat};
  assign rd_shadow_o = '0;
  assign rd_active_o = '0;
`endif

endmodule

// File: tb/tb_crossbar_cfg_ctrl.sv
// Scoreboard bench for crossbar_cfg_ctrl: table-level reference model, randomized writes/commits.
module tb_crossbar_cfg_ctrl;
  localparam int N_IN     = 32;
  localparam int N_OUT    = 24;
  localparam int XBAR_LAT = 1;
  localparam int SEL_W    = $clog2(N_IN);
  localparam int IDX_W    = $clog2(N_OUT);
  localparam int BUSY     = XBAR_LAT + 2;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   wr_valid = 1'b0;
  logic                   wr_ready_o;
  logic [IDX_W-1:0]       wr_idx = '0;
  logic [SEL_W-1:0]       wr_sel = '0;
  logic                   wr_err_o;
  logic                   commit = 1'b0;
  logic                   busy_o;
  logic                   done_o;
  logic [N_OUT*SEL_W-1:0] cfg_o;
  logic [N_OUT-1:0]       gate_o;
  logic [IDX_W-1:0]       rd_idx = '0;
  logic [SEL_W-1:0]       rd_shadow_o;
  logic [SEL_W-1:0]       rd_active_o;

  always #5 clk = ~clk;

  crossbar_cfg_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .XBAR_LAT(XBAR_LAT)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_o),
    .wr_idx_i(wr_idx), .wr_sel_i(wr_sel), .wr_err_o(wr_err_o),
    .commit_i(commit), .busy_o(busy_o), .done_o(done_o),
    .cfg_o(cfg_o), .gate_o(gate_o),
    .rd_idx_i(rd_idx), .rd_shadow_o(rd_shadow_o), .rd_active_o(rd_active_o)
  );

  typedef struct {
    logic [N_OUT*SEL_W-1:0] cfg;
    logic [N_OUT-1:0]       chg;
    logic [SEL_W-1:0]       rb_sh;
    logic [SEL_W-1:0]       rb_ac;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   m_shadow[N_OUT];
  int   m_active[N_OUT];
  int   busy_cnt = 0;
  int   low_cnt[N_OUT];
  exp_t mon_e;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  function automatic logic [N_OUT*SEL_W-1:0] model_cfg();
    logic [N_OUT*SEL_W-1:0] v;
    v = '0;
    for (int k = 0; k < N_OUT; k++) v[k*SEL_W +: SEL_W] = SEL_W'(m_active[k]);
    return v;
  endfunction

  // Monitor: accumulates busy/gate history and checks it whenever done_o is presented.
  always @(negedge clk) begin
    if (!rstn) begin
      busy_cnt = 0;
      for (int k = 0; k < N_OUT; k++) low_cnt[k] = 0;
    end else begin
      if (busy_o) begin
        busy_cnt++;
        for (int k = 0; k < N_OUT; k++) if (!gate_o[k]) low_cnt[k]++;
      end else begin
        chk("idle_gate", 128'(gate_o), 128'({N_OUT{1'b1}}));
      end
      if (wr_err_o) begin
        chk("wr_err_expected", 128'(err_q.size() > 0), 128'(1));
        if (err_q.size() > 0) void'(err_q.pop_front());
      end
      if (done_o) begin
        chk("done_expected", 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) begin
          logic [N_OUT-1:0] ok;
          mon_e = exp_q.pop_front();
          chk("cfg_after_done", 128'(cfg_o), 128'(mon_e.cfg));
          chk("busy_cycles", 128'(busy_cnt), 128'(BUSY));
          for (int k = 0; k < N_OUT; k++)
            ok[k] = (low_cnt[k] == (mon_e.chg[k] ? BUSY : 0));
          chk("gate_window_ok", 128'(ok), 128'({N_OUT{1'b1}}));
          chk("readback", 128'({rd_shadow_o, rd_active_o}), 128'({mon_e.rb_sh, mon_e.rb_ac}));
        end
        busy_cnt = 0;
        for (int k = 0; k < N_OUT; k++) low_cnt[k] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_wr(input int idx, input int sel);
    wr_valid = 1'b1;
    wr_idx   = IDX_W'(idx);
    wr_sel   = SEL_W'(sel);
    if (idx < N_OUT && sel < N_IN) m_shadow[idx] = sel;
    else err_q.push_back(1);
  endtask

  task automatic wr(input int idx, input int sel);
    apply_wr(idx, sel);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_commit(input bit with_wr, input int idx, input int sel);
    exp_t x;
    logic [N_OUT*SEL_W-1:0] prev;
    int n;
    int ri;
    prev   = model_cfg();
    commit = 1'b1;
    ri     = $urandom_range(31);
    rd_idx = IDX_W'(ri);
    if (with_wr) apply_wr(idx, sel);
    for (int k = 0; k < N_OUT; k++) begin
      x.chg[k]    = (m_shadow[k] != m_active[k]);
      m_active[k] = m_shadow[k];
    end
    x.cfg = model_cfg();
`ifdef CROSSBAR_CFG_READBACK_EN
    x.rb_sh = (ri < N_OUT) ? SEL_W'(m_shadow[ri]) : '0;
    x.rb_ac = x.rb_sh;
`else
    x.rb_sh = '0;
    x.rb_ac = '0;
`endif
    exp_q.push_back(x);
    tick();
    commit   = 1'b0;
    wr_valid = 1'b0;
    chk("cfg_held_in_gate", 128'(cfg_o), 128'(prev));
    n = 0;
    while (!done_o && n < 20) begin
      chk("ready_while_busy", 128'(wr_ready_o), 128'(0));
      wr_valid = 1'($urandom_range(1));
      wr_idx   = IDX_W'($urandom_range(31));
      wr_sel   = SEL_W'($urandom_range(31));
      commit   = 1'($urandom_range(1));
      tick();
      n++;
      if (n == 1) chk("cfg_at_E1", 128'(cfg_o), 128'(x.cfg));
    end
    wr_valid = 1'b0;
    commit   = 1'b0;
    chk("done_within_budget", 128'(done_o), 128'(1));
    chk("busy_ticks", 128'(n), 128'(BUSY));
    chk("ready_at_done", 128'(wr_ready_o), 128'(1));
  endtask

  initial begin
    for (int k = 0; k < N_OUT; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
      low_cnt[k]  = 0;
    end
    #12;
    chk("rst_cfg", 128'(cfg_o), 128'(0));
    chk("rst_gate", 128'(gate_o), 128'({N_OUT{1'b1}}));
    chk("rst_ctrl", 128'({busy_o, wr_ready_o, done_o, wr_err_o}), 128'(4'b0100));
    chk("rst_readback", 128'({rd_shadow_o, rd_active_o}), 128'(0));
    @(negedge clk);
    #2 rstn = 1'b1;
    tick();

    // Empty commit: full sequence, no gating.
    do_commit(1'b0, 0, 0);
    // Write on the commit edge is included.
    do_commit(1'b1, 5, 7);
    chk("entry5", 128'(cfg_o[5*SEL_W +: SEL_W]), 128'(7));

    // Out-of-range indices: error pulse, no table effect.
    wr(24, 3);
    wr(31, 1);
    tick();
    do_commit(1'b0, 0, 0);

    // Route sweep: every input to every output.
    for (int i = 0; i < N_IN; i++)
      for (int o = 0; o < N_OUT; o++) begin
        wr(o, i);
        do_commit(1'b0, 0, 0);
      end

    // Random traffic.
    for (int r = 0; r < 150; r++) begin
      int nw;
      nw = $urandom_range(4);
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(3) == 0) tick();
        wr($urandom_range(31), $urandom_range(31));
      end
      do_commit(1'($urandom_range(1)), $urandom_range(31), $urandom_range(31));
    end

    // Reset during SETTLE aborts the commit.
    wr(3, (m_active[3] + 1) % N_IN);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    #2 rstn = 1'b0;
    #1;
    exp_q.delete();
    for (int k = 0; k < N_OUT; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end
    chk("abort_cfg", 128'(cfg_o), 128'(model_cfg()));
    chk("abort_gate", 128'(gate_o), 128'({N_OUT{1'b1}}));
    chk("abort_ctrl", 128'({busy_o, wr_ready_o, done_o}), 128'(3'b010));
    @(negedge clk);
    #2 rstn = 1'b1;
    tick();
    chk("abort_no_done", 128'(done_o), 128'(0));
    do_commit(1'b1, 9, 30);

    repeat (4) tick();
    chk("err_q_drained", 128'(err_q.size()), 128'(0));
    chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
